sync_fifo_fwft: RTL and testbench

- Single-clock, parametrised FIFO with first-word-fall-through (FWFT) read side, occupancy level output and almost-full/almost-empty flags.
- Next generation of the team's pointer-based FIFO, for same-domain buffering between pipeline stages, e.g. DMA and stream adapters.
- Generalised in data width, depth and thresholds.
- Adds FWFT output, level reporting and optional error flags.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 24 ++
 rtl/sync_fifo_fwft.sv | 124 ++++++++++++
 tb/tb_sync_fifo_fwft.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Purpose: shared helpers for sync_fifo_fwft (level width, threshold sanity check).
// Latency: n/a, elaboration-time functions only.
// Backpressure: n/a.
package sync_fifo_pkg;

    function automatic int clog2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Level must represent 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int level_width(input int aw);
        return clog2_ceil((1 << aw) + 1);
    endfunction

    function automatic bit thresh_ok(input int ae, input int af, input int depth);
        return (ae >= 0) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Purpose: simple dual-port RAM, DW x DEPTH, one write and one registered read port.
// Latency: read data valid one clock after re.
// Backpressure: none; caller guarantees address safety.
module sync_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Purpose: single-clock FWFT FIFO with level and almost flags; SYNC_FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: write into empty FIFO shows on rdata two clocks later; pops sustain one word per clock.
// Backpressure: writes dropped while wfull, pops ignored while !rvalid.
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter  int DW        = 8,
    parameter  int AW        = 4,
    parameter  int AF_THRESH = (1 << AW) - 2,
    parameter  int AE_THRESH = 2,
    localparam int LW        = level_width(AW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    output logic          walmost_full,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          rempty,
    output logic          ralmost_empty,
    output logic [LW-1:0] level
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow
`endif
);

    localparam int DEPTH = 1 << AW;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_fwft: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end
    if (DW < 1 || AW < 1 || LW != AW + 1) begin : g_bad_size
        $error("sync_fifo_fwft: DW and AW must be at least 1");
    end

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   ram_cnt;
    logic          mid_vld;
    logic [DW-1:0] ram_q;
    logic          wr_acc;
    logic          pop;
    logic          out_load;
    logic          mid_free;
    logic          rd_issue;

    // Pipeline: RAM array -> RAM read register (mid) -> output register (rdata).
    assign wr_acc   = wen && !wfull;
    assign pop      = ren && rvalid;
    assign out_load = mid_vld && (!rvalid || pop);
    assign mid_free = !mid_vld || out_load;
    assign ram_cnt  = wptr - rptr;
    assign rd_issue = (ram_cnt != '0) && mid_free;

    sync_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_issue),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            mid_vld <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            level   <= '0;
        end else begin
            if (wr_acc)   wptr <= wptr + PTR_ONE;
            if (rd_issue) rptr <= rptr + PTR_ONE;

            if (rd_issue)      mid_vld <= 1'b1;
            else if (out_load) mid_vld <= 1'b0;

            if (out_load) begin
                rvalid <= 1'b1;
                rdata  <= ram_q;
            end else if (pop) begin
                rvalid <= 1'b0;
            end

            level <= level + LW'(wr_acc) - LW'(pop);
        end
    end

    assign wfull         = (level == DEPTH_L);
    assign walmost_full  = (level >= AF_L);
    assign ralmost_empty = (level <= AE_L);
    assign rempty        = !rvalid;

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && wfull)  overflow <= 1'b1;
            else if (err_clr)  overflow <= 1'b0;

            if (ren && !rvalid) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: queue-based reference model where a word is presented once
// it is at the head and at least two edges have passed since it was written.
module tb_sync_fifo_fwft;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wen;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          walmost_full;
    logic          ren;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rempty;
    logic          ralmost_empty;
    logic [AW:0]   level;
`ifdef SYNC_FIFO_ERR_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo_fwft #(
        .DW        (DW),
        .AW        (AW),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wen           (wen),
        .wdata         (wdata),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .ren           (ren),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .level         (level)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr       (err_clr),
        .overflow      (overflow),
        .underflow     (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t q[$];
    int   cyc;
    bit   e_ovf;
    bit   e_unf;
    int   n_chk;
    int   n_fail;

    function automatic bit head_vis();
        return (q.size() > 0) && ((cyc - q[0].t) >= 2);
    endfunction

    function automatic logic [9:0] exp_flags();
        int n;
        bit v;
        n = q.size();
        v = head_vis();
        return {v, !v, n == DEPTH, n >= 14, n <= 2, 5'(n)};
    endfunction

    function automatic logic [9:0] obs_flags();
        return {rvalid, rempty, wfull, walmost_full, ralmost_empty, level};
    endfunction

    // One clock: drive inputs, advance the reference model across the edge, settle.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit vis;
        bit full;
        wen   = w;
        wdata = d;
        ren   = r;
        vis   = head_vis();
        full  = (q.size() == DEPTH);
        @(posedge clk);
        cyc++;
`ifdef SYNC_FIFO_ERR_EN
        if (w && full)     e_ovf = 1'b1;
        else if (err_clr)  e_ovf = 1'b0;
        if (r && !vis)     e_unf = 1'b1;
        else if (err_clr)  e_unf = 1'b0;
`endif
        if (r && vis) void'(q.pop_front());
        if (w && !full) q.push_back('{d, cyc});
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        wdata = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        #1 rst = 1'b1;
        #2;
        n_chk++;
        if (obs_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", obs_flags(), exp_flags());
        end
        n_chk++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
`ifdef SYNC_FIFO_ERR_EN
        n_chk++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 00", {overflow, underflow});
        end
`endif
        #9 rst = 1'b0;
    endtask

    task automatic test_first_word();
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs_flags() !== exp_flags()) begin
                n_fail++;
                $display("FAIL first_word_flags edge=%0d: got %b want %b", i + 1, obs_flags(), exp_flags());
            end
            if (head_vis()) begin
                n_chk++;
                if (rdata !== q[0].d) begin
                    n_fail++;
                    $display("FAIL first_word_rdata: got %h want %h", rdata, q[0].d);
                end
            end
            if (i < 2) step(1'b0, '0, 1'b0);
        end
        step(1'b0, '0, 1'b1);
        n_chk++;
        if (obs_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL first_word_pop: got %b want %b", obs_flags(), exp_flags());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b1, (i < DEPTH) ? DW'(i) : 8'h99, 1'b0);
            n_chk++;
            if (obs_flags() !== exp_flags()) begin
                n_fail++;
                $display("FAIL fill_flags i=%0d: got %b want %b", i, obs_flags(), exp_flags());
            end
        end
        step(1'b1, 8'h77, 1'b1);
        n_chk++;
        if (obs_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL full_wr_pop_flags: got %b want %b", obs_flags(), exp_flags());
        end
        n_chk++;
        if (!head_vis() || rdata !== q[0].d) begin
            n_fail++;
            $display("FAIL full_wr_pop_rdata: got %h want %h", rdata, 8'h01);
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 40 && q.size() > 5; g++) step(1'b0, '0, 1'b1);
        n_chk++;
        if (level !== 5'd5) begin
            n_fail++;
            $display("FAIL b2b_prefill: got level %0d want 5", level);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, DW'($urandom), 1'b1);
            n_chk++;
            if (obs_flags() !== exp_flags() || level !== 5'd5 || rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_flags i=%0d: got %b want %b", i, obs_flags(), exp_flags());
            end
            if (head_vis()) begin
                n_chk++;
                if (rdata !== q[0].d) begin
                    n_fail++;
                    $display("FAIL b2b_rdata i=%0d: got %h want %h", i, rdata, q[0].d);
                end
            end
        end
        for (int g = 0; g < 40 && q.size() > 0; g++) step(1'b0, '0, 1'b1);
        n_chk++;
        if (obs_flags() !== exp_flags() || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %b want %b", obs_flags(), exp_flags());
        end
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b1);
        n_chk++;
        if (obs_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL underflow_flags: got %b want %b", obs_flags(), exp_flags());
        end
`ifdef SYNC_FIFO_ERR_EN
        for (int i = 0; i < 3; i++) begin
            err_clr = (i == 1);
            step(1'b0, '0, 1'b0);
            err_clr = 1'b0;
            n_chk++;
            if ({overflow, underflow} !== {e_ovf, e_unf}) begin
                n_fail++;
                $display("FAIL err_flags i=%0d: got %b want %b", i, {overflow, underflow}, {e_ovf, e_unf});
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
        n_chk++;
        if (level !== 5'd9) begin
            n_fail++;
            $display("FAIL mid_prefill: got level %0d want 9", level);
        end
        #3 rst = 1'b1;
        q.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
        #1;
        n_chk++;
        if (obs_flags() !== exp_flags() || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got %b/%h want %b/00", obs_flags(), rdata, exp_flags());
        end
        #3;
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs_flags() !== exp_flags()) begin
                n_fail++;
                $display("FAIL post_reset_flags edge=%0d: got %b want %b", i + 1, obs_flags(), exp_flags());
            end
            if (i < 2) step(1'b0, '0, 1'b0);
        end
        n_chk++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL post_reset_rdata: got %b/%h want 1/3c", rvalid, rdata);
        end
    endtask

    task automatic test_random();
        int wp;
        int rp;
        for (int ph = 0; ph < 3; ph++) begin
            wp = 80 - 30 * ph;
            rp = 20 + 30 * ph;
            for (int i = 0; i < 200; i++) begin
`ifdef SYNC_FIFO_ERR_EN
                err_clr = ($urandom_range(0, 9) == 0);
`endif
                step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
                n_chk++;
                if (obs_flags() !== exp_flags()) begin
                    n_fail++;
                    $display("FAIL rand_flags ph=%0d i=%0d: got %b want %b", ph, i, obs_flags(), exp_flags());
                end
                if (head_vis()) begin
                    n_chk++;
                    if (rdata !== q[0].d) begin
                        n_fail++;
                        $display("FAIL rand_rdata ph=%0d i=%0d: got %h want %h", ph, i, rdata, q[0].d);
                    end
                end
`ifdef SYNC_FIFO_ERR_EN
                n_chk++;
                if ({overflow, underflow} !== {e_ovf, e_unf}) begin
                    n_fail++;
                    $display("FAIL rand_err ph=%0d i=%0d: got %b want %b", ph, i, {overflow, underflow}, {e_ovf, e_unf});
                end
`endif
            end
        end
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        e_ovf  = 1'b0;
        e_unf  = 1'b0;
        test_reset();
        test_first_word();
        test_fill();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
